// File: rtl/serial_cla_subtractor_pkg.sv
// Shared constants and FSM state type for the serial CLA subtractor.
package serial_cla_subtractor_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SLICE  = 4;
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_cla_subtractor_if.sv
// Request/response handshake bundle for the serial CLA subtractor.
interface serial_cla_subtractor_if;
    import serial_cla_subtractor_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;

    // Requester side: issues operands, consumes the result.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow, zero
    );

    // Subtractor side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow, zero
    );

endinterface

// File: rtl/serial_cla_subtractor_cla_slice4.sv
// Combinational 4-bit carry-look-ahead adder slice.
module cla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Propagate/generate terms and flattened look-ahead carries C1..C4.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/serial_cla_subtractor.sv
// Multi-cycle A - B: one 4-bit CLA slice per clock, valid/ready in and out.
module serial_cla_subtractor
    import serial_cla_subtractor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    serial_cla_subtractor_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [CNT_W-1:0] cnt;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] final_diff_c;
    logic             accept_c;
    logic             step_c;
    logic             last_c;
    logic             release_c;

    cla_slice4 u_cla (
        .a    (a_sh[SLICE-1:0]),
        .b    (b_sh[SLICE-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Full result as it will look once the current slice is shifted in.
    assign final_diff_c = {slice_sum, res_sh[WIDTH-1:SLICE]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        step_c     = 1'b0;
        last_c     = 1'b0;
        release_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (cnt == CNT_W'(NSLICE - 1)) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    release_c  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand/result shift registers, slice counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh         <= '0;
            b_sh         <= '0;
            res_sh       <= '0;
            carry        <= 1'b0;
            a_msb        <= 1'b0;
            b_msb        <= 1'b0;
            cnt          <= '0;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.diff     <= '0;
            bus.borrow   <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b0;
        end else begin
            if (accept_c) begin
                // Subtraction as A + ~B + 1.
                a_sh         <= bus.a;
                b_sh         <= ~bus.b;
                carry        <= 1'b1;
                cnt          <= '0;
                a_msb        <= bus.a[WIDTH-1];
                b_msb        <= bus.b[WIDTH-1];
                bus.in_ready <= 1'b0;
            end
            if (step_c) begin
                a_sh   <= {SLICE'(0), a_sh[WIDTH-1:SLICE]};
                b_sh   <= {SLICE'(0), b_sh[WIDTH-1:SLICE]};
                res_sh <= final_diff_c;
                carry  <= slice_cout;
                cnt    <= cnt + CNT_W'(1);
            end
            if (last_c) begin
                bus.diff      <= final_diff_c;
                bus.borrow    <= ~slice_cout;
                bus.zero      <= (final_diff_c == '0);
                bus.overflow  <= (a_msb != b_msb) && (final_diff_c[WIDTH-1] != a_msb);
                bus.out_valid <= 1'b1;
            end
            if (release_c) begin
                bus.out_valid <= 1'b0;
                bus.in_ready  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Randomized self-checking bench for serial_cla_subtractor.
module tb_serial_cla_subtractor;
    import serial_cla_subtractor_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    serial_cla_subtractor_if bus();

    serial_cla_subtractor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: modular difference, unsigned compare, signed range check.
    function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] d, output logic bo,
                                  output logic ov, output logic z);
        longint sd;
        d  = av - bv;
        bo = (av < bv);
        sd = longint'($signed(av)) - longint'($signed(bv));
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        z  = (d == 32'd0);
    endfunction

    // Drives one request, waits for the result, optionally stalls, then completes the handshake.
    task automatic transact(input logic [31:0] av, input logic [31:0] bv, input int hold,
                            output int lat, output logic [31:0] d, output logic bo,
                            output logic ov, output logic z,
                            output logic vld_after, output logic rdy_after);
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d  = bus.diff;
        bo = bus.borrow;
        ov = bus.overflow;
        z  = bus.zero;
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        vld_after = bus.out_valid;
        rdy_after = bus.in_ready;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        total++;
        if ({bus.diff, bus.borrow, bus.overflow, bus.zero} !== 35'h0) begin
            bad++;
            $display("FAIL reset_data: diff=%h b/o/z=%b%b%b required all zero",
                     bus.diff, bus.borrow, bus.overflow, bus.zero);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        int lat;
        logic [31:0] d, ed;
        logic bo, ov, z, ebo, eov, ez, va, ra;
        ta = '{32'h0000_0005, 32'h0000_0003, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000, 32'h1234_5678};
        tb = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1234_5678};
        for (int i = 0; i < 6; i++) begin
            model(ta[i], tb[i], ed, ebo, eov, ez);
            transact(ta[i], tb[i], 0, lat, d, bo, ov, z, va, ra);
            total++;
            if (lat !== 8) begin
                bad++;
                $display("FAIL dir%0d_latency: got %0d required 8", i, lat);
            end
            total++;
            if (d !== ed) begin
                bad++;
                $display("FAIL dir%0d_diff: got %h required %h", i, d, ed);
            end
            total++;
            if ({bo, ov, z} !== {ebo, eov, ez}) begin
                bad++;
                $display("FAIL dir%0d_flags: b/o/z got %b%b%b required %b%b%b", i, bo, ov, z, ebo, eov, ez);
            end
            total++;
            if (va !== 1'b0 || ra !== 1'b1) begin
                bad++;
                $display("FAIL dir%0d_handshake: out_valid=%b in_ready=%b required 0/1", i, va, ra);
            end
        end
        // 0 - 1 wrap-around
        transact(32'h0, 32'h1, 1, lat, d, bo, ov, z, va, ra);
        total++;
        if ({d, bo, ov, z} !== {32'hFFFF_FFFF, 3'b100}) begin
            bad++;
            $display("FAIL wrap: diff=%h b/o/z=%b%b%b required ffffffff 100", d, bo, ov, z);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] av, bv, d, ed;
        logic bo, ov, z, ebo, eov, ez, va, ra;
        for (int i = 0; i < 40; i++) begin
            av = $urandom;
            case ($urandom_range(0, 3))
                0: bv = $urandom;
                1: bv = av;
                2: bv = av + 32'($urandom_range(0, 20));
                default: bv = {av[31], 31'($urandom)};
            endcase
            model(av, bv, ed, ebo, eov, ez);
            transact(av, bv, int'($urandom_range(0, 3)), lat, d, bo, ov, z, va, ra);
            total++;
            if (lat !== 8 || d !== ed || {bo, ov, z} !== {ebo, eov, ez} || va !== 1'b0 || ra !== 1'b1) begin
                bad++;
                $display("FAIL rand%0d: a=%h b=%h lat=%0d diff=%h bov z=%b%b%b hs=%b%b required lat=8 diff=%h %b%b%b hs=01",
                         i, av, bv, lat, d, bo, ov, z, va, ra, ed, ebo, eov, ez);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] av, bv, ed;
        logic ebo, eov, ez;
        int k;
        av = 32'h8000_0000;
        bv = 32'h0000_0001;
        model(av, bv, ed, ebo, eov, ez);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== ed
                || {bus.borrow, bus.overflow, bus.zero} !== {ebo, eov, ez}) begin
                bad++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b diff=%h bov z=%b%b%b required 1 0 %h %b%b%b",
                         c, bus.out_valid, bus.in_ready, bus.diff, bus.borrow, bus.overflow, bus.zero,
                         ed, ebo, eov, ez);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== ed) begin
            bad++;
            $display("FAIL bp_release: vld=%b rdy=%b diff=%h required 0 1 %h",
                     bus.out_valid, bus.in_ready, bus.diff, ed);
        end
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) k++;
        end
        total++;
        if (k !== 0) begin
            bad++;
            $display("FAIL bp_ignored: %0d cycles left idle required 0", k);
        end
    endtask

    task automatic test_reset_abort();
        int lat, k;
        logic [31:0] av, bv, d, ed;
        logic bo, ov, z, ebo, eov, ez, va, ra;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h0000_1111;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 32'h0) begin
            bad++;
            $display("FAIL abort_state: rdy=%b vld=%b diff=%h required 1 0 00000000",
                     bus.in_ready, bus.out_valid, bus.diff);
        end
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) k++;
        end
        total++;
        if (k !== 0) begin
            bad++;
            $display("FAIL abort_no_result: out_valid high %0d cycles required 0", k);
        end
        av = $urandom;
        bv = $urandom;
        model(av, bv, ed, ebo, eov, ez);
        transact(av, bv, 0, lat, d, bo, ov, z, va, ra);
        total++;
        if (lat !== 8 || d !== ed || {bo, ov, z} !== {ebo, eov, ez}) begin
            bad++;
            $display("FAIL abort_next_op: lat=%0d diff=%h bov z=%b%b%b required 8 %h %b%b%b",
                     lat, d, bo, ov, z, ed, ebo, eov, ez);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
